// File: rtl/rng.sv
// rtl/rng.sv - free-running xorshift32 generator whose output register samples on a request edge
module rng #(
    parameter logic [31:0] SEED = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        changeNum,
    output logic [31:0] randNum
);

    // An all-zero state would lock the generator at zero forever.
    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h0000_0001 : SEED;

    function automatic logic [31:0] xs(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    logic [31:0] s_q, s_d;
    logic        chg_q, chg_d;
    logic [31:0] rand_q, rand_d;
    logic        rise;

    always_comb begin
        rise   = changeNum & ~chg_q;
        s_d    = xs(s_q);
        chg_d  = changeNum;
        rand_d = rand_q;
        // Capture the pre-advance state so the value depends on request timing.
        if (rise) begin
            rand_d = s_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s_q    <= SEED_EFF;
            chg_q  <= 1'b0;
            rand_q <= 32'h0;
        end else begin
            s_q    <= s_d;
            chg_q  <= chg_d;
            rand_q <= rand_d;
        end
    end

    assign randNum = rand_q;

endmodule

// File: tb/tb_rng.sv
// tb/tb_rng.sv - directed self-checking bench for rng
`timescale 1ns/1ps
module tb_rng;

    logic        clk;
    logic        reset;
    logic        changeNum;
    logic [31:0] rand_a;
    logic [31:0] rand_z;
    int          errors;
    int          checks;
    logic [31:0] exp_v;

    rng #(.SEED(32'h0000_0001)) dut (
        .clk       (clk),
        .reset     (reset),
        .changeNum (changeNum),
        .randNum   (rand_a)
    );

    rng #(.SEED(32'h0000_0000)) dut_z (
        .clk       (clk),
        .reset     (reset),
        .changeNum (changeNum),
        .randNum   (rand_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] xs_n(input logic [31:0] x0, input int n);
        logic [31:0] x;
        x = x0;
        for (int i = 0; i < n; i++) begin
            x = x ^ (x << 13);
            x = x ^ (x >> 17);
            x = x ^ (x << 5);
        end
        return x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic c);
        @(negedge clk);
        reset     = r;
        changeNum = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        reset     = 1'b0;
        changeNum = 1'b0;

        // Reset holds the output at zero
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            chk("reset_rand", rand_a, 32'h0);
            chk("reset_rand_seed0", rand_z, 32'h0);
        end

        // First capture: low then high after release
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("first_capture", rand_a, 32'h0004_2021);
        chk("first_capture_seed0", rand_z, 32'h0004_2021);

        // Held request gives exactly one capture
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1);
            chk("held_request", rand_a, 32'h0004_2021);
        end

        // One low edge re-arms; nine edges since release, eight advances before capture
        step(1'b1, 1'b0);
        chk("rearm_low_hold", rand_a, 32'h0004_2021);
        step(1'b1, 1'b1);
        exp_v = xs_n(32'h1, 8);
        chk("rearm_capture", rand_a, exp_v);
        chk("rearm_capture_seed0", rand_z, exp_v);

        // Reset wins over a coincident rise
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        chk("reset_wins_rand", rand_a, 32'h0);
        chk("reset_wins_state", dut.s_q, 32'h1);
        chk("reset_wins_state_seed0", dut_z.s_q, 32'h1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("post_reset_capture", rand_a, 32'h0004_2021);
        chk("post_reset_capture_seed0", rand_z, 32'h0004_2021);

        // Back-to-back single-cycle pulses
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        chk("pulse1", rand_a, 32'h0000_0001);
        chk("pulse1_seed0", rand_z, 32'h0000_0001);
        step(1'b1, 1'b0);
        chk("pulse_gap", rand_a, 32'h0000_0001);
        step(1'b1, 1'b1);
        chk("pulse3", rand_a, 32'h0408_0601);
        chk("pulse3_seed0", rand_z, 32'h0408_0601);

        // Request held through reset counts as a rise on the first release edge
        step(1'b0, 1'b1);
        chk("hold_in_reset", rand_a, 32'h0);
        step(1'b1, 1'b1);
        chk("release_capture_seed", rand_a, 32'h0000_0001);
        chk("release_capture_seed0", rand_z, 32'h0000_0001);
        step(1'b1, 1'b1);
        chk("release_held", rand_a, 32'h0000_0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
